// File: rtl/xaui_link_pkg.sv
// Shared state encoding and parameter defaults for the XAUI link bring-up controller.
package xaui_link_pkg;

  typedef enum logic [2:0] {
    ST_POWERDOWN = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_ALIGN     = 3'd3,
    ST_CHAN_SYNC = 3'd4,
    ST_UP        = 3'd5
  } link_state_e;

  localparam int DEF_RESET_CYCLES  = 64;
  localparam int DEF_LOCK_TIMEOUT  = 4096;
  localparam int DEF_ALIGN_TIMEOUT = 65536;
  localparam int DEF_ALIGN_HOLD    = 16;
  localparam int DEF_CHSYNC_CYCLES = 32;

  localparam int TIMER_W = 17;

endpackage

// File: rtl/xaui_link_ctrl.sv
// Four-lane XAUI transceiver bring-up sequencer: reset, CDR lock, comma alignment,
// channel bonding, then link monitoring with retry accounting.
//
// state     | meaning
// POWERDOWN | link disabled, transceivers powered down and held in reset
// RESET     | MGT resets asserted for RESET_CYCLES
// WAIT_LOCK | waiting for all four CDRs to lock
// ALIGN     | comma alignment, needs ALIGN_HOLD consecutive clean cycles
// CHAN_SYNC | channel bonding pulse for CHSYNC_CYCLES
// UP        | link operational, monitored for lock/sync/buffer faults
module xaui_link_ctrl
  import xaui_link_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int ALIGN_TIMEOUT = DEF_ALIGN_TIMEOUT,
  parameter int ALIGN_HOLD    = DEF_ALIGN_HOLD,
  parameter int CHSYNC_CYCLES = DEF_CHSYNC_CYCLES
) (
  input  logic       mgt_clk,
  input  logic       reset_n,
  input  logic       link_en,
  input  logic [3:0] mgt_rxlock,
  input  logic [3:0] mgt_syncok,
  input  logic [7:0] mgt_code_valid,
  input  logic [3:0] mgt_rxbufferr,
  output logic [3:0] mgt_rx_reset,
  output logic [3:0] mgt_tx_reset,
  output logic [3:0] mgt_enable_align,
  output logic       mgt_en_chan_sync,
  output logic       mgt_powerdown,
  output logic       link_up,
  output logic [7:0] retry_count,
  output logic [2:0] state
);

  localparam logic [TIMER_W-1:0] TIMER_MAX    = '1;
  localparam logic [TIMER_W-1:0] RESET_LAST   = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] ALIGN_LAST   = TIMER_W'(ALIGN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(ALIGN_HOLD - 1);
  localparam logic [TIMER_W-1:0] CHSYNC_LAST  = TIMER_W'(CHSYNC_CYCLES - 1);

  link_state_e        state_q, state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] hold_q;
  logic [7:0]         retry_q;
  logic               fail;
  logic               lock_all;
  logic               sync_good;
  logic               hold_done;

  assign lock_all  = (mgt_rxlock == 4'hF);
  assign sync_good = (mgt_syncok == 4'hF) && (mgt_code_valid == 8'hFF);
  assign hold_done = sync_good && (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    fail    = 1'b0;
    case (state_q)
      ST_POWERDOWN: if (link_en) state_d = ST_RESET;
      ST_RESET:     if (timer_q == RESET_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_all) state_d = ST_ALIGN;
        else if (timer_q == LOCK_LAST) fail = 1'b1;
      end
      ST_ALIGN: begin
        if (timer_q == ALIGN_LAST && !hold_done) fail = 1'b1;
        else if (hold_done) state_d = ST_ALIGN == ST_ALIGN ? ST_CHAN_SYNC : ST_ALIGN;
      end
      ST_CHAN_SYNC: begin
        // A buffer error on the final bonding cycle still counts as a failure.
        if (mgt_rxbufferr != 4'h0) fail = 1'b1;
        else if (timer_q == CHSYNC_LAST) state_d = ST_UP;
      end
      ST_UP: begin
        if (!lock_all || mgt_syncok != 4'hF || mgt_rxbufferr != 4'h0) fail = 1'b1;
      end
      default: state_d = ST_POWERDOWN;
    endcase
    if (fail) state_d = ST_RESET;
    if (!link_en) begin
      state_d = ST_POWERDOWN;
      fail    = 1'b0;
    end
  end

  always_ff @(posedge mgt_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_POWERDOWN;
      timer_q <= '0;
      hold_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      // Timer saturates so idle states (POWERDOWN, UP) never wrap it.
      if (state_d != state_q || fail) timer_q <= '0;
      else if (timer_q != TIMER_MAX) timer_q <= timer_q + 1'b1;
      if (state_q == ST_ALIGN && state_d == ST_ALIGN && sync_good) hold_q <= hold_q + 1'b1;
      else hold_q <= '0;
      if (fail && retry_q != 8'hFF) retry_q <= retry_q + 1'b1;
    end
  end

  always_comb begin
    mgt_powerdown    = 1'b0;
    mgt_rx_reset     = 4'h0;
    mgt_tx_reset     = 4'h0;
    mgt_enable_align = 4'h0;
    mgt_en_chan_sync = 1'b0;
    link_up          = 1'b0;
    case (state_q)
      ST_POWERDOWN: begin
        mgt_powerdown = 1'b1;
        mgt_rx_reset  = 4'hF;
        mgt_tx_reset  = 4'hF;
      end
      ST_RESET: begin
        mgt_rx_reset = 4'hF;
        mgt_tx_reset = 4'hF;
      end
      ST_WAIT_LOCK: ;
      ST_ALIGN:     mgt_enable_align = 4'hF;
      ST_CHAN_SYNC: begin
        mgt_enable_align = 4'hF;
        mgt_en_chan_sync = 1'b1;
      end
      ST_UP: begin
        mgt_enable_align = 4'hF;
        link_up          = 1'b1;
      end
      default: begin
        mgt_powerdown = 1'b1;
        mgt_rx_reset  = 4'hF;
        mgt_tx_reset  = 4'hF;
      end
    endcase
  end

  assign retry_count = retry_q;
  assign state       = state_q;

endmodule
